// File: rtl/perm_out_ser_pkg.sv
// perm_pkg: shared types and constants for the permutation output serialiser.
//   state_e          : framing FSM states (IDLE, HDR, DATA)
//   lane_t           : one queued lane (lane-0 marker + 64-bit data)
//   LANES_PER_STATE  : lanes in one 1600-bit state
//   BYTES_PER_LANE   : bytes serialised per lane
//   IDLE_BYTE        : byte driven on the NoC between frames
//   lane_byte()      : little-endian byte select from a lane
package perm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_e;

  localparam int unsigned LANES_PER_STATE = 25;
  localparam int unsigned BYTES_PER_LANE  = 8;
  localparam int unsigned LANE_W          = 64;
  localparam logic [7:0]  IDLE_BYTE       = 8'h00;

  typedef struct packed {
    logic              first;
    logic [LANE_W-1:0] data;
  } lane_t;

  // Byte 0 is bits 7:0.
  function automatic logic [7:0] lane_byte(input logic [LANE_W-1:0] lane,
                                           input logic [2:0]        idx);
    return lane[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/perm_out_ser_lane_fifo.sv
// lane_fifo: circular FIFO with a one-entry look-ahead read port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push_i / wdata_i    : write an entry (ignored when full)
//   pop_i               : drop the head entry (ignored when empty)
//   head_o              : entry at the head
//   next_o              : low PEEK_W bits of the entry behind the head
//   full_o, empty_o     : occupancy flags
//   count_o             : number of stored entries
module lane_fifo #(
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  WIDTH  = 65,
  parameter int unsigned  PEEK_W = WIDTH,
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  head_o,
  output logic [PEEK_W-1:0] next_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rd_nxt  = wrap_inc(rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt][PEEK_W-1:0];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/perm_out_ser.sv
// perm_out_ser: queues 64-bit lanes from the permutation block and serialises
// each 25-lane state onto the NoC as a header byte followed by 200 data bytes.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   pushout   : lane offered;  firstout : offered lane is lane 0;  dout : lane
//   stopout   : backpressure (FIFO full)
//   noc_stall : NoC cannot take a byte this cycle
//   frm_ctl   : 1 for idle/header bytes, 0 for data bytes
//   frm_data  : NoC byte (registered)
//   seq_err   : sticky lane-0 marker inconsistency
module perm_out_ser
  import perm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  input  logic        noc_stall,
  output logic        frm_ctl,
  output logic [7:0]  frm_data,
  output logic        seq_err
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [4:0]  LAST_LANE = 5'(LANES_PER_STATE - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(BYTES_PER_LANE - 1);

  lane_t             wr_lane;
  lane_t             fifo_head;
  logic [LANE_W-1:0] fifo_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_count;

  state_e            state_q;
  logic [4:0]        lane_cnt_q;
  logic [2:0]        byte_cnt_q;
  logic              starve_q;
  logic              seq_err_q;
  logic              frm_ctl_q;
  logic [7:0]        frm_data_q;

  logic              lane_end;
  logic              more_queued;
  logic              head_bad;

  assign wr_lane   = '{first: firstout, data: dout};
  assign fifo_push = pushout && !fifo_full;
  assign stopout   = fifo_full;
  assign frm_ctl   = frm_ctl_q;
  assign frm_data  = frm_data_q;
  assign seq_err   = seq_err_q;

  lane_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  ($bits(lane_t)),
    .PEEK_W (LANE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .wdata_i (wr_lane),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    lane_end    = (state_q == DATA) && !starve_q && (byte_cnt_q == LAST_BYTE);
    fifo_pop    = lane_end && !noc_stall;
    // The lane behind the head is needed to emit its byte 0 on the pop edge.
    more_queued = (fifo_count > CW'(1));
    head_bad    = (lane_cnt_q == '0) ? !fifo_head.first : fifo_head.first;
  end

  // Outputs are computed for the state being entered, so frm_data always
  // shows the byte indexed by byte_cnt_q of the current lane. starve_q marks
  // a mid-frame gap: the lane was popped, the next one has not arrived, and
  // the last byte stays on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      byte_cnt_q <= '0;
      starve_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      frm_ctl_q  <= 1'b1;
      frm_data_q <= IDLE_BYTE;
    end else if (!noc_stall) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= HDR;
            frm_ctl_q  <= 1'b1;
            frm_data_q <= HDR_BYTE;
          end
        end
        HDR: begin
          state_q    <= DATA;
          lane_cnt_q <= '0;
          byte_cnt_q <= '0;
          starve_q   <= 1'b0;
          frm_ctl_q  <= 1'b0;
          frm_data_q <= lane_byte(fifo_head.data, 3'd0);
        end
        DATA: begin
          if (starve_q) begin
            if (!fifo_empty) begin
              starve_q   <= 1'b0;
              frm_data_q <= lane_byte(fifo_head.data, 3'd0);
            end
          end else if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_q <= byte_cnt_q + 3'd1;
            frm_data_q <= lane_byte(fifo_head.data, byte_cnt_q + 3'd1);
          end else begin
            if (head_bad) seq_err_q <= 1'b1;
            byte_cnt_q <= '0;
            if (lane_cnt_q == LAST_LANE) begin
              lane_cnt_q <= '0;
              frm_ctl_q  <= 1'b1;
              if (more_queued) begin
                state_q    <= HDR;
                frm_data_q <= HDR_BYTE;
              end else begin
                state_q    <= IDLE;
                frm_data_q <= IDLE_BYTE;
              end
            end else begin
              lane_cnt_q <= lane_cnt_q + 5'd1;
              if (more_queued) frm_data_q <= lane_byte(fifo_next, 3'd0);
              else             starve_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/perm_out_ser.md
PERM_OUT_SER -- requirements
Module: perm_out_ser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of 64-bit lane entries in the input FIFO.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, giving the frame header byte value.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pushout, input, 1 bit: a lane is offered by the permutation block.
REQ-006 SHALL have port firstout, input, 1 bit: the offered lane is lane 0 of a 1600-bit state.
REQ-007 SHALL have port dout, input, 64 bits: the offered lane data.
REQ-008 SHALL have port stopout, output, 1 bit: backpressure to the permutation block.
REQ-009 SHALL have port noc_stall, input, 1 bit: the NoC cannot take a byte this cycle.
REQ-010 SHALL have port frm_ctl, output, 1 bit: NoC control flag.
REQ-011 SHALL have port frm_data, output, 8 bits: NoC byte.
REQ-012 SHALL have port seq_err, output, 1 bit: sticky framing error.

Function
REQ-013 SHALL accept a lane exactly when pushout=1 and stopout=0; dout and firstout are then written to the FIFO tail.
REQ-014 SHALL drive stopout=1 combinationally whenever the FIFO holds FIFO_DEPTH entries; otherwise stopout=0.
REQ-015 SHALL, when the FIFO is full, not accept a push even if a pop occurs in the same cycle.
REQ-016 SHALL allow a push and a pop in the same cycle when not full; the count is then unchanged.
REQ-017 SHALL implement FSM states IDLE, HDR and DATA.
REQ-018 SHALL, in IDLE, drive frm_ctl=1 and frm_data=8'h00.
REQ-019 SHALL go IDLE->HDR on the edge where the FIFO is non-empty and noc_stall=0.
REQ-020 SHALL, in HDR, drive frm_ctl=1 and frm_data=HDR_BYTE.
REQ-021 SHALL go HDR->DATA on the next non-stalled edge, with lane_cnt=0 and byte_cnt=0.
REQ-022 SHALL, in DATA, drive frm_ctl=0 and frm_data=byte byte_cnt of the FIFO head lane, little-endian (byte 0 = bits 7:0).
REQ-023 SHALL advance byte_cnt (0..7) on each non-stalled DATA edge.
REQ-024 SHALL, when byte_cnt=7, pop the head lane and advance lane_cnt (0..24).
REQ-025 SHALL, after byte 7 of lane 24, go to HDR if the FIFO holds another entry after the pop, else to IDLE.
REQ-026 SHALL, in DATA with byte_cnt=7 and the FIFO empty after the pop (lane_cnt<24), hold the last byte and freeze until a lane arrives; it SHALL NOT emit idle mid-frame.
REQ-027 SHALL, while noc_stall=1, hold frm_ctl, frm_data, state and counters unchanged; FIFO pushes still proceed.
REQ-028 SHALL register frm_ctl/frm_data; the header appears 1 cycle after the first lane is accepted into an empty FIFO in IDLE, the first data byte 2 cycles after, and the last byte of lane 24 201 cycles after, given no stall or starvation.
REQ-029 SHALL set seq_err when a popped lane-0 head has firstout=0, or a head with lane_cnt≠0 has firstout=1; framing continues by lane_cnt.
REQ-030 SHALL hold seq_err at 1 until reset.

Reset
REQ-031 SHALL, while reset=0, force FSM=IDLE, FIFO empty, lane_cnt=0, byte_cnt=0, seq_err=0, frm_ctl=1, frm_data=8'h00 and stopout=0, independent of clk.
REQ-032 SHALL, on reset assertion mid-frame, discard the partial frame and all FIFO contents; the first post-reset frame starts with a header.

Structure
REQ-033 SHALL import from package perm_pkg the state enum (IDLE, HDR, DATA), LANES_PER_STATE=25, BYTES_PER_LANE=8 and the idle byte value.
REQ-034 SHALL implement the lane FIFO as sub-module lane_fifo (parameterised depth/width, push/pop/full/empty/count).

Verification
REQ-035 SHALL cover: 25 lanes pushed back-to-back, lane0 with firstout=1, data = lane index ×0x0101010101010101 -> header 0xA5, then 200 bytes, lane k bytes all =k, then idle 0x00.
REQ-036 SHALL cover: 6 lanes pushed with noc_stall=1 -> stopout rises once 4 are accepted, lanes 5-6 held off, no data lost after noc_stall drops.
REQ-037 SHALL cover: noc_stall pulsed for 3 cycles during lane 2 byte 4 -> that byte is held 4 cycles, sequence unchanged.
REQ-038 SHALL cover: lane 0 pushed with firstout=0 -> seq_err=1 on pop, frame still 200 bytes, seq_err held until reset.
REQ-039 SHALL cover: reset=0 asserted at lane 10 -> frm_data=0x00 and frm_ctl=1 immediately; a new 25-lane push yields a fresh header.
REQ-040 SHALL cover: two states pushed back-to-back -> header of frame 2 directly follows the last byte of frame 1, with no idle byte.
